// File: rtl/opendap_apb_arb2_pkg.sv
// rtl/opendap_apb_arb2_pkg.sv - shared types and helpers for the two-requester APB arbiter
//
// Contents:
//   W_ADDR_DEF / W_DATA_DEF  default bus widths used by the interface and the top
//   state_e                  transfer sequencer states IDLE -> SETUP -> ACCESS -> RESP
//   port_e                   requester identifier (A or B), used for grant and priority
//   other_port()             the requester that is not p
//   rr_pick()                two-way round-robin choice between pending requesters
package opendap_apb_arb2_pkg;

  localparam int W_ADDR_DEF = 8;
  localparam int W_DATA_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

  // Both pending: the priority holder wins. One pending: it wins.
  // Neither pending: result is don't-care, callers only use it when a request exists.
  function automatic port_e rr_pick(input logic req_a, input logic req_b, input port_e prio);
    if (req_a && req_b) begin
      return prio;
    end
    return req_b ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/opendap_apb_arb2_if.sv
// rtl/opendap_apb_arb2_if.sv - APB bus bundle used for both requester and completer ports
//
// Signals:
//   psel, penable, pwrite, paddr, pwdata   driven by the requester side
//   prdata, pready, pslverr                driven by the completer side
// Modports:
//   master  the side that issues transfers (the arbiter's downstream port)
//   slave   the side that answers transfers (the arbiter's upstream ports)
interface opendap_apb_arb2_if
  import opendap_apb_arb2_pkg::*;
#(
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int W_DATA = W_DATA_DEF
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [W_ADDR-1:0] paddr;
  logic [W_DATA-1:0] pwdata;
  logic [W_DATA-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/opendap_apb_arb2.sv
// rtl/opendap_apb_arb2.sv - round-robin arbiter sharing one APB completer between two requesters
//
// Ports:
//   clk     single clock for all three buses
//   rst_n   asynchronous active-low reset (synchronised externally)
//   a       requester A upstream port (slave modport): psel/pwrite/paddr/pwdata in,
//           prdata/pready/pslverr out; penable is not used
//   b       requester B upstream port, same as a
//   m       downstream completer port (master modport)
//
// One transfer is in flight at a time. Every downstream request field and every
// upstream response field comes straight from a flop, so no combinational path
// crosses the arbiter in either direction.
module opendap_apb_arb2
  import opendap_apb_arb2_pkg::*;
#(
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int W_DATA = W_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  opendap_apb_arb2_if.slave        a,
  opendap_apb_arb2_if.slave        b,
  opendap_apb_arb2_if.master       m
);

  state_e            state_q,     state_d;
  port_e             grant_q,     grant_d;
  port_e             prio_q,      prio_d;
  port_e             win;

  logic              m_psel_q,    m_psel_d;
  logic              m_penable_q, m_penable_d;
  logic              m_pwrite_q,  m_pwrite_d;
  logic [W_ADDR-1:0] m_paddr_q,   m_paddr_d;
  logic [W_DATA-1:0] m_pwdata_q,  m_pwdata_d;

  logic              a_pready_q,  a_pready_d;
  logic              a_pslverr_q, a_pslverr_d;
  logic [W_DATA-1:0] a_prdata_q,  a_prdata_d;
  logic              b_pready_q,  b_pready_d;
  logic              b_pslverr_q, b_pslverr_d;
  logic [W_DATA-1:0] b_prdata_q,  b_prdata_d;

  // Requesters present valid setup-phase fields with psel alone, so penable
  // carries no information for the arbiter.
  logic              unused_penable;
  assign unused_penable = a.penable ^ b.penable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= PORT_A;
      prio_q      <= PORT_A;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      m_pwrite_q  <= 1'b0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      a_pready_q  <= 1'b0;
      a_pslverr_q <= 1'b0;
      a_prdata_q  <= '0;
      b_pready_q  <= 1'b0;
      b_pslverr_q <= 1'b0;
      b_prdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      m_pwrite_q  <= m_pwrite_d;
      m_paddr_q   <= m_paddr_d;
      m_pwdata_q  <= m_pwdata_d;
      a_pready_q  <= a_pready_d;
      a_pslverr_q <= a_pslverr_d;
      a_prdata_q  <= a_prdata_d;
      b_pready_q  <= b_pready_d;
      b_pslverr_q <= b_pslverr_d;
      b_prdata_q  <= b_prdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    m_pwrite_d  = m_pwrite_q;
    m_paddr_d   = m_paddr_q;
    m_pwdata_d  = m_pwdata_q;
    // pready is a single-cycle pulse; response data holds between pulses.
    a_pready_d  = 1'b0;
    a_pslverr_d = a_pslverr_q;
    a_prdata_d  = a_prdata_q;
    b_pready_d  = 1'b0;
    b_pslverr_d = b_pslverr_q;
    b_prdata_d  = b_prdata_q;

    win = rr_pick(a.psel, b.psel, prio_q);

    case (state_q)
      ST_IDLE: begin
        if (a.psel || b.psel) begin
          grant_d  = win;
          m_psel_d = 1'b1;
          state_d  = ST_SETUP;
          if (win == PORT_B) begin
            m_pwrite_d = b.pwrite;
            m_paddr_d  = b.paddr;
            m_pwdata_d = b.pwdata;
          end else begin
            m_pwrite_d = a.pwrite;
            m_paddr_d  = a.paddr;
            m_pwdata_d = a.pwdata;
          end
        end
      end

      // Fixed one-cycle setup phase; m.pready seen here is deliberately ignored.
      ST_SETUP: begin
        m_penable_d = 1'b1;
        state_d     = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (m.pready) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = ST_RESP;
          if (grant_q == PORT_B) begin
            b_pready_d  = 1'b1;
            b_prdata_d  = m.prdata;
            b_pslverr_d = m.pslverr;
          end else begin
            a_pready_d  = 1'b1;
            a_prdata_d  = m.prdata;
            a_pslverr_d = m.pslverr;
          end
        end
      end

      // The granted requester sees its pready pulse during this state. Priority
      // moves to the other port so continuous requesters alternate.
      ST_RESP: begin
        prio_d  = other_port(grant_q);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m.psel    = m_psel_q;
  assign m.penable = m_penable_q;
  assign m.pwrite  = m_pwrite_q;
  assign m.paddr   = m_paddr_q;
  assign m.pwdata  = m_pwdata_q;

  assign a.pready  = a_pready_q;
  assign a.pslverr = a_pslverr_q;
  assign a.prdata  = a_prdata_q;
  assign b.pready  = b_pready_q;
  assign b.pslverr = b_pslverr_q;
  assign b.prdata  = b_prdata_q;

endmodule

// File: tb/tb_opendap_apb_arb2.sv
// tb/tb_opendap_apb_arb2.sv - self-checking bench for opendap_apb_arb2
module tb_opendap_apb_arb2;

  localparam int W_ADDR = 8;
  localparam int W_DATA = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opendap_apb_arb2_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) a_if ();
  opendap_apb_arb2_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) b_if ();
  opendap_apb_arb2_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) m_if ();

  opendap_apb_arb2 #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if),
    .m     (m_if)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus tables for the traffic runner: per-port requests, per-transfer completer replies.
  logic [W_ADDR-1:0] req_addr [2][16];
  logic              req_wr   [2][16];
  logic [W_DATA-1:0] req_wd   [2][16];
  int                req_n    [2];
  logic [W_DATA-1:0] rsp_data [32];
  logic              rsp_err  [32];
  int                rsp_wait [32];

  // Observations in completion order.
  int                obs_port  [$];
  logic [W_DATA-1:0] obs_rdata [$];
  logic              obs_err   [$];
  logic [W_ADDR-1:0] obs_maddr [$];
  logic              obs_mwr   [$];
  logic [W_DATA-1:0] obs_mwd   [$];

  // Reference model: transaction-level round-robin.
  int model_prio = 0;
  int exp_port [$];

  // Protocol monitor on the downstream bus and upstream ready pulses.
  logic              prev_psel = 1'b0;
  logic              prev_pwrite;
  logic [W_ADDR-1:0] prev_paddr;
  logic [W_DATA-1:0] prev_pwdata;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (m_if.penable && !m_if.psel) begin
        errors++;
        $display("FAIL penable_implies_psel: penable=%b psel=%b", m_if.penable, m_if.psel);
      end
      checks++;
      if (a_if.pready && b_if.pready) begin
        errors++;
        $display("FAIL one_pready: a_pready=%b b_pready=%b required at most one", a_if.pready, b_if.pready);
      end
      if (m_if.psel && prev_psel) begin
        checks++;
        if (m_if.paddr !== prev_paddr || m_if.pwdata !== prev_pwdata || m_if.pwrite !== prev_pwrite) begin
          errors++;
          $display("FAIL m_fields_stable: got %h/%h/%b required %h/%h/%b",
                   m_if.paddr, m_if.pwdata, m_if.pwrite, prev_paddr, prev_pwdata, prev_pwrite);
        end
      end
      prev_psel   = m_if.psel;
      prev_paddr  = m_if.paddr;
      prev_pwdata = m_if.pwdata;
      prev_pwrite = m_if.pwrite;
    end else begin
      prev_psel = 1'b0;
    end
  end

  task automatic clear_inputs();
    a_if.psel = 1'b0; a_if.penable = 1'b0; a_if.pwrite = 1'b0; a_if.paddr = '0; a_if.pwdata = '0;
    b_if.psel = 1'b0; b_if.penable = 1'b0; b_if.pwrite = 1'b0; b_if.paddr = '0; b_if.pwdata = '0;
    m_if.pready = 1'b0; m_if.prdata = '0; m_if.pslverr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_prio = 0;
  endtask

  task automatic set_req(input int p, input bit active, input int k);
    if (p == 0) begin
      a_if.psel    = active;
      a_if.penable = 1'($urandom_range(0, 1));
      if (active) begin
        a_if.paddr = req_addr[0][k]; a_if.pwrite = req_wr[0][k]; a_if.pwdata = req_wd[0][k];
      end
    end else begin
      b_if.psel    = active;
      b_if.penable = 1'($urandom_range(0, 1));
      if (active) begin
        b_if.paddr = req_addr[1][k]; b_if.pwrite = req_wr[1][k]; b_if.pwdata = req_wd[1][k];
      end
    end
  endtask

  task automatic gen_traffic(input int na, input int nb, input int max_wait);
    req_n[0] = na;
    req_n[1] = nb;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 16; k++) begin
        req_addr[p][k] = 8'($urandom);
        req_wr[p][k]   = 1'($urandom_range(0, 1));
        req_wd[p][k]   = $urandom;
      end
    end
    for (int i = 0; i < 32; i++) begin
      rsp_data[i] = $urandom;
      rsp_err[i]  = 1'($urandom_range(0, 1));
      rsp_wait[i] = $urandom_range(0, max_wait);
    end
  endtask

  // Requesters keep psel up until their pready pulse, then immediately present
  // their next request; the completer answers ACCESS cycles after rsp_wait cycles
  // and throws random pready/data at SETUP cycles.
  task automatic run_traffic(output bit timed_out);
    int idx [2];
    int done_cnt;
    int total;
    int wcnt;
    int rsp_i;
    int cyc;
    idx[0] = 0; idx[1] = 0;
    done_cnt = 0; wcnt = 0; rsp_i = 0; cyc = 0;
    total = req_n[0] + req_n[1];
    obs_port.delete(); obs_rdata.delete(); obs_err.delete();
    obs_maddr.delete(); obs_mwr.delete(); obs_mwd.delete();
    set_req(0, req_n[0] > 0, 0);
    set_req(1, req_n[1] > 0, 0);
    while (done_cnt < total && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (m_if.psel && m_if.penable && rsp_i < 32) begin
        if (wcnt < rsp_wait[rsp_i]) begin
          m_if.pready = 1'b0;
          wcnt++;
        end else begin
          m_if.pready  = 1'b1;
          m_if.prdata  = rsp_data[rsp_i];
          m_if.pslverr = rsp_err[rsp_i];
          obs_maddr.push_back(m_if.paddr);
          obs_mwr.push_back(m_if.pwrite);
          obs_mwd.push_back(m_if.pwdata);
          rsp_i++;
          wcnt = 0;
        end
      end else begin
        m_if.pready  = m_if.psel ? 1'($urandom_range(0, 1)) : 1'b0;
        m_if.prdata  = $urandom;
        m_if.pslverr = 1'($urandom_range(0, 1));
      end
      if (a_if.pready) begin
        obs_port.push_back(0); obs_rdata.push_back(a_if.prdata); obs_err.push_back(a_if.pslverr);
        idx[0]++; done_cnt++;
        set_req(0, idx[0] < req_n[0], idx[0]);
      end
      if (b_if.pready) begin
        obs_port.push_back(1); obs_rdata.push_back(b_if.prdata); obs_err.push_back(b_if.pslverr);
        idx[1]++; done_cnt++;
        set_req(1, idx[1] < req_n[1], idx[1]);
      end
    end
    a_if.psel = 1'b0;
    b_if.psel = 1'b0;
    m_if.pready = 1'b0;
    timed_out = (done_cnt < total);
  endtask

  // Each port with outstanding work is pending at every arbitration; both
  // pending -> priority holder, else the pending one; priority then passes on.
  task automatic model_predict(input int na, input int nb);
    int left [2];
    left[0] = na; left[1] = nb;
    exp_port.delete();
    while (left[0] + left[1] > 0) begin
      int w;
      if (left[0] > 0 && left[1] > 0) w = model_prio;
      else w = (left[0] > 0) ? 0 : 1;
      exp_port.push_back(w);
      left[w]--;
      model_prio = 1 - w;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (m_if.psel !== 1'b0 || m_if.penable !== 1'b0) begin
      errors++; $display("FAIL reset_m_ctrl: psel=%b penable=%b required 0/0", m_if.psel, m_if.penable);
    end
    checks++;
    if (m_if.paddr !== '0 || m_if.pwdata !== '0 || m_if.pwrite !== 1'b0) begin
      errors++; $display("FAIL reset_m_fields: %h/%h/%b required zeros", m_if.paddr, m_if.pwdata, m_if.pwrite);
    end
    checks++;
    if (a_if.pready !== 1'b0 || a_if.pslverr !== 1'b0 || a_if.prdata !== '0) begin
      errors++; $display("FAIL reset_a_rsp: %b/%b/%h required zeros", a_if.pready, a_if.pslverr, a_if.prdata);
    end
    checks++;
    if (b_if.pready !== 1'b0 || b_if.pslverr !== 1'b0 || b_if.prdata !== '0) begin
      errors++; $display("FAIL reset_b_rsp: %b/%b/%h required zeros", b_if.pready, b_if.pslverr, b_if.prdata);
    end
    rst_n = 1'b1;
    model_prio = 0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    a_if.psel = 1'b1; a_if.pwrite = 1'b0; a_if.paddr = 8'h24; a_if.penable = 1'b0;
    @(negedge clk);
    checks++;
    if (m_if.psel !== 1'b1 || m_if.penable !== 1'b0 || m_if.paddr !== 8'h24 || m_if.pwrite !== 1'b0) begin
      errors++; $display("FAIL single_setup: psel=%b penable=%b paddr=%h pwrite=%b required 1/0/24/0",
                         m_if.psel, m_if.penable, m_if.paddr, m_if.pwrite);
    end
    a_if.penable = 1'b1;
    @(negedge clk);
    checks++;
    if (m_if.psel !== 1'b1 || m_if.penable !== 1'b1 || a_if.pready !== 1'b0) begin
      errors++; $display("FAIL single_access: psel=%b penable=%b a_pready=%b required 1/1/0",
                         m_if.psel, m_if.penable, a_if.pready);
    end
    m_if.pready = 1'b1; m_if.prdata = 32'hCAFEF00D; m_if.pslverr = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.pready !== 1'b1 || a_if.prdata !== 32'hCAFEF00D || a_if.pslverr !== 1'b0) begin
      errors++; $display("FAIL single_resp: a_pready=%b a_prdata=%h a_pslverr=%b required 1/cafef00d/0",
                         a_if.pready, a_if.prdata, a_if.pslverr);
    end
    checks++;
    if (m_if.psel !== 1'b0 || b_if.pready !== 1'b0) begin
      errors++; $display("FAIL single_resp_idle: m_psel=%b b_pready=%b required 0/0", m_if.psel, b_if.pready);
    end
    m_if.pready = 1'b0; a_if.psel = 1'b0; a_if.penable = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.pready !== 1'b0 || a_if.prdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL single_hold: a_pready=%b a_prdata=%h required 0/cafef00d", a_if.pready, a_if.prdata);
    end
  endtask

  task automatic test_both_from_reset();
    bit to;
    do_reset();
    gen_traffic(3, 3, 2);
    run_traffic(to);
    checks++;
    if (to || obs_port.size() != 6) begin
      errors++; $display("FAIL both_count: got %0d responses required 6 (timeout=%b)", obs_port.size(), to);
    end
    for (int i = 0; i < obs_port.size() && i < 6; i++) begin
      checks++;
      if (obs_port[i] != (i % 2)) begin
        errors++; $display("FAIL both_order[%0d]: got port %0d required %0d", i, obs_port[i], i % 2);
      end
      checks++;
      if (obs_rdata[i] !== rsp_data[i] || obs_err[i] !== rsp_err[i]) begin
        errors++; $display("FAIL both_rsp[%0d]: got %h/%b required %h/%b", i, obs_rdata[i], obs_err[i],
                           rsp_data[i], rsp_err[i]);
      end
    end
  endtask

  task automatic test_b_write_wait();
    int n;
    int extra;
    @(negedge clk);
    b_if.psel = 1'b1; b_if.pwrite = 1'b1; b_if.paddr = 8'h10; b_if.pwdata = 32'h12345678;
    n = 0;
    while (!(m_if.psel && m_if.penable) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_if.psel && m_if.penable)) begin
      errors++; $display("FAIL bwait_access_timeout: psel=%b penable=%b required 1/1", m_if.psel, m_if.penable);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_if.paddr !== 8'h10 || m_if.pwdata !== 32'h12345678 || m_if.pwrite !== 1'b1 ||
          m_if.penable !== 1'b1 || b_if.pready !== 1'b0) begin
        errors++; $display("FAIL bwait_hold[%0d]: %h/%h/%b penable=%b b_pready=%b required 10/12345678/1/1/0",
                           i, m_if.paddr, m_if.pwdata, m_if.pwrite, m_if.penable, b_if.pready);
      end
      @(negedge clk);
    end
    m_if.pready = 1'b1; m_if.prdata = 32'h0BADF00D; m_if.pslverr = 1'b0;
    @(negedge clk);
    checks++;
    if (b_if.pready !== 1'b1 || a_if.pready !== 1'b0 || b_if.prdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL bwait_resp: b_pready=%b a_pready=%b b_prdata=%h required 1/0/0badf00d",
                         b_if.pready, a_if.pready, b_if.prdata);
    end
    m_if.pready = 1'b0; b_if.psel = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b_if.pready) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL bwait_single_pulse: got %0d extra b_pready cycles required 0", extra);
    end
  endtask

  task automatic test_slverr();
    bit to;
    do_reset();
    gen_traffic(2, 0, 1);
    req_wr[0][0] = 1'b0;
    req_wr[0][1] = 1'b0;
    rsp_err[0] = 1'b1;
    rsp_err[1] = 1'b0;
    run_traffic(to);
    checks++;
    if (to || obs_port.size() != 2) begin
      errors++; $display("FAIL slverr_count: got %0d responses required 2 (timeout=%b)", obs_port.size(), to);
    end else begin
      checks++;
      if (obs_port[0] != 0 || obs_err[0] !== 1'b1) begin
        errors++; $display("FAIL slverr_first: port=%0d err=%b required 0/1", obs_port[0], obs_err[0]);
      end
      checks++;
      if (obs_port[1] != 0 || obs_err[1] !== 1'b0 || obs_rdata[1] !== rsp_data[1]) begin
        errors++; $display("FAIL slverr_clear: port=%0d err=%b rdata=%h required 0/0/%h",
                           obs_port[1], obs_err[1], obs_rdata[1], rsp_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int n;
    @(negedge clk);
    b_if.psel = 1'b1; b_if.pwrite = 1'b0; b_if.paddr = 8'h5A; b_if.pwdata = 32'h0;
    n = 0;
    while (!(m_if.psel && m_if.penable) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_if.psel && m_if.penable)) begin
      errors++; $display("FAIL rstmid_access_timeout: psel=%b penable=%b required 1/1", m_if.psel, m_if.penable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_if.psel !== 1'b0 || m_if.penable !== 1'b0 || a_if.pready !== 1'b0 || b_if.pready !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: psel=%b penable=%b a_pready=%b b_pready=%b required 0/0/0/0",
                         m_if.psel, m_if.penable, a_if.pready, b_if.pready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_prio = 0;
    @(negedge clk);
    checks++;
    if (m_if.psel !== 1'b1 || m_if.penable !== 1'b0 || m_if.paddr !== 8'h5A) begin
      errors++; $display("FAIL rstmid_regrant: psel=%b penable=%b paddr=%h required 1/0/5a",
                         m_if.psel, m_if.penable, m_if.paddr);
    end
    @(negedge clk);
    m_if.pready = 1'b1; m_if.prdata = 32'h600DCAFE; m_if.pslverr = 1'b0;
    @(negedge clk);
    checks++;
    if (b_if.pready !== 1'b1 || b_if.prdata !== 32'h600DCAFE) begin
      errors++; $display("FAIL rstmid_b_served: b_pready=%b b_prdata=%h required 1/600dcafe", b_if.pready, b_if.prdata);
    end
    m_if.pready = 1'b0; b_if.psel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit to;
    int na;
    int nb;
    int k [2];
    do_reset();
    for (int round = 0; round < 6; round++) begin
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na + nb == 0) na = 1;
      gen_traffic(na, nb, 3);
      run_traffic(to);
      model_predict(na, nb);
      checks++;
      if (to || obs_port.size() != exp_port.size() || obs_maddr.size() != exp_port.size()) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d/%0d responses required %0d (timeout=%b)",
                           round, obs_port.size(), obs_maddr.size(), exp_port.size(), to);
      end else begin
        k[0] = 0; k[1] = 0;
        for (int i = 0; i < exp_port.size(); i++) begin
          int p;
          int j;
          p = exp_port[i];
          j = k[p];
          k[p]++;
          checks++;
          if (obs_port[i] != p) begin
            errors++; $display("FAIL rand_port[%0d.%0d]: got %0d required %0d", round, i, obs_port[i], p);
          end
          checks++;
          if (obs_maddr[i] !== req_addr[p][j] || obs_mwr[i] !== req_wr[p][j] || obs_mwd[i] !== req_wd[p][j]) begin
            errors++; $display("FAIL rand_fields[%0d.%0d]: got %h/%b/%h required %h/%b/%h", round, i,
                               obs_maddr[i], obs_mwr[i], obs_mwd[i], req_addr[p][j], req_wr[p][j], req_wd[p][j]);
          end
          checks++;
          if (obs_rdata[i] !== rsp_data[i] || obs_err[i] !== rsp_err[i]) begin
            errors++; $display("FAIL rand_rsp[%0d.%0d]: got %h/%b required %h/%b", round, i,
                               obs_rdata[i], obs_err[i], rsp_data[i], rsp_err[i]);
          end
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_both_from_reset();
    test_b_write_wait();
    test_slverr();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
